// File: rtl/elm_hidden_layer_engine.sv
// elm_hidden_layer_engine: multi-lane ELM hidden layer, h[j] = ReLU(sum_i x[i]*w[j][i]) with LFSR-generated weights.
// Optional build macro ELM_ACC_SAT_EN: saturating accumulation instead of two's-complement wrap.
module elm_hidden_layer_engine #(
    parameter int          N_INPUTS  = 256,
    parameter int          N_NEURONS = 8192,
    parameter int          LANES     = 4,
    parameter int          ACC_W     = 16,
    parameter logic [7:0]  SEED      = 8'h01
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start,
    output logic [$clog2(N_INPUTS)-1:0]                         inp_add,
    input  logic                                                inp_data,
    output logic [LANES*ACC_W-1:0]                              h_out,
    output logic [(N_NEURONS > 1 ? $clog2(N_NEURONS) : 1)-1:0]  h_index,
    output logic                                                h_valid,
    input  logic                                                h_ready,
    output logic                                                busy,
    output logic                                                done
);
    localparam int AW = $clog2(N_INPUTS);
    localparam int IW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1;
    localparam int NG = N_NEURONS / LANES;
    localparam int GW = NG > 1 ? $clog2(NG) : 1;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, FIN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [GW-1:0]    group_q, group_d;
    logic             rd_q, rd_d;
    logic             clr, reload;
    logic [ACC_W-1:0] acc_q [LANES];
    logic [ACC_W-1:0] acc_d [LANES];
    logic [7:0]       lfsr_q [LANES];
    logic [7:0]       lfsr_d [LANES];

    function automatic logic [7:0] seed_f(input int l);
        logic [7:0] s;
        s = SEED + 8'(8'h1D * l);
        return s == 8'h00 ? 8'h01 : s;
    endfunction

    // Controller: sequences address passes, drains the last read, and hands out one beat per group.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        group_d = group_q;
        rd_d    = 1'b0;
        clr     = 1'b0;
        reload  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                addr_d  = '0;
                group_d = '0;
                clr     = 1'b1;
                reload  = 1'b1;
            end
            RUN: begin
                rd_d   = 1'b1;
                addr_d = addr_q + 1'b1;
                if (addr_q == AW'(N_INPUTS - 1)) state_d = DRAIN;
            end
            DRAIN: state_d = OUT;
            OUT: if (h_ready) begin
                if (group_q == GW'(NG - 1)) state_d = FIN;
                else begin
                    state_d = RUN;
                    group_d = group_q + 1'b1;
                    addr_d  = '0;
                    clr     = 1'b1;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [ACC_W:0] sum;
        logic [ACC_W-1:0]      nxt;
        assign sum = (ACC_W+1)'($signed(acc_q[l])) + (ACC_W+1)'($signed(lfsr_q[l]));
`ifdef ELM_ACC_SAT_EN
        assign nxt = sum[ACC_W] != sum[ACC_W-1] ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
`else
        assign nxt = sum[ACC_W-1:0];
`endif
        assign acc_d[l]  = clr ? '0 : (rd_q && inp_data) ? nxt : acc_q[l];
        assign lfsr_d[l] = reload ? seed_f(l)
                         : rd_q ? {lfsr_q[l][6:0], lfsr_q[l][7] ^ lfsr_q[l][5] ^ lfsr_q[l][4] ^ lfsr_q[l][3]}
                         : lfsr_q[l];
        assign h_out[l*ACC_W +: ACC_W] = (state_q == OUT && !acc_q[l][ACC_W-1]) ? acc_q[l] : '0;
    end

    assign inp_add = addr_q;
    assign h_index = state_q == OUT ? IW'(32'(group_q) * LANES) : '0;
    assign h_valid = state_q == OUT;
    assign busy    = state_q == RUN || state_q == DRAIN || state_q == OUT;
    assign done    = state_q == FIN;

    // State, accumulator and weight-generator registers; reset reloads the lane seeds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            group_q <= '0;
            rd_q    <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i]  <= '0;
                lfsr_q[i] <= seed_f(i);
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            group_q <= group_d;
            rd_q    <= rd_d;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i]  <= acc_d[i];
                lfsr_q[i] <= lfsr_d[i];
            end
        end
    end
endmodule

// File: tb/tb_elm_hidden_layer_engine.sv
// tb_elm_hidden_layer_engine: scoreboard bench for a 4-input, 4-neuron, 2-lane engine.
module tb_elm_hidden_layer_engine;
    logic        clk = 0;
    logic        rst = 0;
    logic        start = 0;
    logic [1:0]  inp_add;
    logic        inp_data = 0;
    logic [31:0] h_out;
    logic [1:0]  h_index;
    logic        h_valid;
    logic        h_ready = 1;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] h;
    } beat_t;

    beat_t sb[$];
    logic  mem [4];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    hs_cyc = -10;

    elm_hidden_layer_engine #(
        .N_INPUTS(4), .N_NEURONS(4), .LANES(2), .ACC_W(16), .SEED(8'h01)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .inp_add(inp_add), .inp_data(inp_data),
        .h_out(h_out), .h_index(h_index), .h_valid(h_valid), .h_ready(h_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) inp_data <= mem[inp_add];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && h_valid && h_ready) begin
            chk("beat_expected", 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                beat_t e;
                e = sb.pop_front();
                chk("h_index", h_index, e.idx);
                chk("h_out", h_out, e.h);
            end
            hs_cyc <= cyc;
        end
        if (rst && done) begin
            chk("done_after_handshake", cyc, hs_cyc + 1);
            chk("busy_at_done", busy, 0);
        end
    end

    task automatic run(input logic [3:0] x, input logic [31:0] e0, input logic [31:0] e1,
                       input int stall, input bit dbl);
        int lat;
        int n;
        logic [31:0] hv;
        logic [1:0]  hi;
        logic [1:0]  ad;
        for (int a = 0; a < 4; a++) mem[a] = x[a];
        sb.push_back('{2'd0, e0});
        sb.push_back('{2'd2, e1});
        h_ready = (stall == 0);
        @(posedge clk); #1 start = 1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            start = dbl && lat == 2;
        end while (!h_valid && lat < 50);
        start = 0;
        chk("latency", lat, 6);
        if (stall > 0) begin
            hv = h_out;
            hi = h_index;
            ad = inp_add;
            repeat (stall) begin
                @(posedge clk); #1;
                chk("stall_valid", h_valid, 1);
                chk("stall_h_out", h_out, hv);
                chk("stall_h_index", h_index, hi);
                chk("stall_inp_add", inp_add, ad);
            end
            h_ready = 1;
        end
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", done, 1);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        for (int a = 0; a < 4; a++) mem[a] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_h_valid", h_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_inp_add", inp_add, 0);
        chk("rst_h_out", h_out, 0);
        chk("rst_h_index", h_index, 0);
        rst = 1;
        run(4'b0000, 32'h0000_0000, 32'h0000_0000, 0, 0);
        run(4'b1111, 32'h00C6_000F, 32'h0000_0009, 5, 0);
        run(4'b0101, 32'h0097_0005, 32'h0000_0058, 0, 1);
        for (int a = 0; a < 4; a++) mem[a] = 1;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        chk("midrun_rst_valid", h_valid, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_inp_add", inp_add, 0);
        rst = 1;
        repeat (15) @(posedge clk);
        #1;
        chk("no_beat_after_rst", busy, 0);
        run(4'b1110, 32'h00A8_000E, 32'h0000_0000, 0, 0);
        run(4'b1001, 32'h0011_0009, 32'h0020_0000, 0, 0);
        run(4'b1111, 32'h00C6_000F, 32'h0000_0009, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
